// File: rtl/rv32ima_pkg.sv
// Shared types for the core's memory path: load/store widths and the memory
// port arbiter state encoding.
package rv32ima_pkg;

   localparam int LDST_WIDTH_W = 2;

   typedef enum logic [LDST_WIDTH_W-1:0] {
      LDST_B = 2'd0,
      LDST_H = 2'd1,
      LDST_W = 2'd2
   } ldst_width_t;

   typedef enum logic [2:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP_I,
      RESP_D
   } memarb_state_t;

   // Per-access formatting context kept for the duration of a data access.
   typedef struct packed {
      ldst_width_t width;
      logic [1:0]  lane;
      logic        load_unsigned;
   } ld_ctx_t;

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting for loads and stores: byte enables, lane replication,
// load extraction with sign/zero extension, and alignment check. Combinational.
module mem_lane_fmt
   import rv32ima_pkg::*;
(
   input  logic [LDST_WIDTH_W-1:0] width,
   input  logic [1:0]              lane,
   input  logic                    load_unsigned,
   input  logic [31:0]             wdata,
   input  logic [31:0]             rdata,
   output logic [3:0]              be,
   output logic [31:0]             wdata_rep,
   output logic [31:0]             rdata_ext,
   output logic                    misalign
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   always_comb begin
      rbyte     = rdata[{lane, 3'b000} +: 8];
      rhalf     = rdata[{lane[1], 4'b0000} +: 16];
      be        = 4'b0000;
      wdata_rep = wdata;
      rdata_ext = rdata;
      misalign  = 1'b0;
      case (width)
         LDST_B: begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{wdata[7:0]}};
            rdata_ext = {{24{rbyte[7] & ~load_unsigned}}, rbyte};
         end
         LDST_H: begin
            be        = 4'b0011 << lane;
            wdata_rep = {2{wdata[15:0]}};
            rdata_ext = {{16{rhalf[15] & ~load_unsigned}}, rhalf};
            misalign  = lane[0];
         end
         LDST_W: begin
            be       = 4'b1111;
            misalign = (lane != 2'b00);
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word memory port between fetch and data; one access in flight.
// Ready 2 cycles after grant plus mem_ack wait cycles (1 if misaligned); requests held until ready.
module mem_port_arbiter
   import rv32ima_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter bit DATA_FIRST = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_req,
   input  logic [ADDR_W-1:0]       i_addr,
   output logic [DATA_W-1:0]       i_rdata,
   output logic                    i_ready,
   output logic                    i_misalign,
   input  logic                    d_ren,
   input  logic                    d_wen,
   input  logic [ADDR_W-1:0]       d_addr,
   input  logic [DATA_W-1:0]       d_wdata,
   input  logic [LDST_WIDTH_W-1:0] d_width,
   input  logic                    d_load_unsigned,
   output logic [DATA_W-1:0]       d_rdata,
   output logic                    d_ready,
   output logic                    d_misalign,
   output logic                    mem_req,
   output logic                    mem_wen,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [DATA_W-1:0]       mem_wdata,
   output logic [3:0]              mem_be,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_ack
);

   memarb_state_t     state;
   ld_ctx_t           ctx;
   ld_ctx_t           fmt_ctx;
   logic [3:0]        fmt_be;
   logic [DATA_W-1:0] fmt_wdata;
   logic [DATA_W-1:0] fmt_rdata;
   logic              fmt_mis;
   logic              grant_d;
   logic              grant_i;
   logic              i_mis;

   // Live request feeds the formatter while idle; latched context while busy.
   always_comb begin
      fmt_ctx = ctx;
      if (state == IDLE) begin
         fmt_ctx = '{width: ldst_width_t'(d_width), lane: d_addr[1:0],
                     load_unsigned: d_load_unsigned};
      end
   end

   assign grant_d = (d_wen | d_ren) & (DATA_FIRST | ~i_req);
   assign grant_i = i_req & ~grant_d;
   assign i_mis   = (i_addr[1:0] != 2'b00);

   mem_lane_fmt u_fmt (
      .width         (fmt_ctx.width),
      .lane          (fmt_ctx.lane),
      .load_unsigned (fmt_ctx.load_unsigned),
      .wdata         (d_wdata),
      .rdata         (mem_rdata),
      .be            (fmt_be),
      .wdata_rep     (fmt_wdata),
      .rdata_ext     (fmt_rdata),
      .misalign      (fmt_mis)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ctx        <= '{width: LDST_W, lane: 2'b00, load_unsigned: 1'b0};
         mem_req    <= 1'b0;
         mem_wen    <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= 4'b0000;
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_misalign <= 1'b0;
         d_misalign <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  ctx <= fmt_ctx;
                  if (fmt_mis) begin
                     d_misalign <= 1'b1;
                     d_rdata    <= '0;
                     d_ready    <= 1'b1;
                     state      <= RESP_D;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_wen   <= d_wen;
                     mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata <= d_wen ? fmt_wdata : '0;
                     mem_be    <= d_wen ? fmt_be : 4'b1111;
                     state     <= BUSY_D;
                  end
               end else if (grant_i) begin
                  if (i_mis) begin
                     i_misalign <= 1'b1;
                     i_rdata    <= '0;
                     i_ready    <= 1'b1;
                     state      <= RESP_I;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_wen   <= 1'b0;
                     mem_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                     mem_wdata <= '0;
                     mem_be    <= 4'b1111;
                     state     <= BUSY_I;
                  end
               end
            end
            BUSY_I: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  i_rdata <= mem_rdata;
                  i_ready <= 1'b1;
                  state   <= RESP_I;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_wen <= 1'b0;
                  d_rdata <= mem_wen ? '0 : fmt_rdata;
                  d_ready <= 1'b1;
                  state   <= RESP_D;
               end
            end
            RESP_I: begin
               i_ready    <= 1'b0;
               i_misalign <= 1'b0;
               state      <= IDLE;
            end
            RESP_D: begin
               d_ready    <= 1'b0;
               d_misalign <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against an arithmetic
// reference of the load/store lane rules and the access timing.
module tb_mem_port_arbiter;
   import rv32ima_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic        i_misalign;
   logic        d_ren;
   logic        d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [1:0]  d_width;
   logic        d_load_unsigned;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        d_misalign;
   logic        mem_req;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .i_misalign(i_misalign),
      .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_width(d_width), .d_load_unsigned(d_load_unsigned), .d_rdata(d_rdata),
      .d_ready(d_ready), .d_misalign(d_misalign),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference rules: access size is 1 << width bytes and must be size-aligned.
   function automatic bit ref_mis(input logic [1:0] w, input logic [31:0] a);
      int sz;
      if (w == 2'd3) return 1'b1;
      sz = 1 << w;
      return (a % sz) != 0;
   endfunction

   function automatic logic [31:0] ref_be(input logic [1:0] w, input logic [31:0] a);
      int be_i;
      be_i = ((1 << (1 << w)) - 1) << (a % 4);
      return 32'(be_i[3:0]);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [1:0] w, input logic [31:0] wd);
      logic [31:0] b;
      logic [31:0] h;
      b = {24'h0, wd[7:0]};
      h = {16'h0, wd[15:0]};
      if (w == 2'd0) return b * 32'h01010101;
      if (w == 2'd1) return h * 32'h00010001;
      return wd;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] w, input logic [31:0] a,
                                            input logic lu, input logic [31:0] rd);
      int          bits;
      logic [31:0] sh;
      logic [31:0] mask;
      logic [31:0] v;
      if (w == 2'd2) return rd;
      bits = 8 << w;
      sh   = (w == 2'd0) ? (rd >> (8 * (a % 4))) : (rd >> (16 * ((a % 4) / 2)));
      mask = (32'h1 << bits) - 32'h1;
      v    = sh & mask;
      if (!lu && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   // Runs one data access from IDLE; inputs are driven and outputs sampled at negedges.
   task automatic data_op(input string tag, input logic wen, input logic ren,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] w, input logic lu, input int waits,
                          input logic [31:0] rd, output logic [31:0] got);
      bit mis;
      int n;
      mis = ref_mis(w, addr);
      d_wen = wen; d_ren = ren; d_addr = addr; d_wdata = wdata;
      d_width = w; d_load_unsigned = lu;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req && !d_ready && n < 20);
      if (mis) begin
         check({tag, " mis latency"}, 32'(n), 32'd1);
         check({tag, " mis ready"}, 32'(d_ready), 32'd1);
         check({tag, " mis flag"}, 32'(d_misalign), 32'd1);
         check({tag, " mis rdata"}, d_rdata, 32'd0);
         check({tag, " mis no req"}, 32'(mem_req), 32'd0);
      end else begin
         check({tag, " req latency"}, 32'(n), 32'd1);
         check({tag, " addr"}, mem_addr, addr & ~32'd3);
         check({tag, " wen"}, 32'(mem_wen), 32'(wen));
         check({tag, " be"}, 32'(mem_be), wen ? ref_be(w, addr) : 32'hF);
         if (wen) check({tag, " wdata"}, mem_wdata, ref_wdata(w, wdata));
         for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            check({tag, " wait hold"}, {30'd0, mem_req, d_ready}, 32'd2);
         end
         mem_ack = 1'b1; mem_rdata = rd;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = $urandom;
         check({tag, " ready"}, 32'(d_ready), 32'd1);
         check({tag, " no mis"}, 32'(d_misalign), 32'd0);
         check({tag, " req drop"}, 32'(mem_req), 32'd0);
         check({tag, " rdata"}, d_rdata, wen ? 32'd0 : ref_load(w, addr, lu, rd));
      end
      got = d_rdata;
      d_wen = 1'b0; d_ren = 1'b0;
      @(negedge clk);
      check({tag, " ready pulse"}, 32'(d_ready), 32'd0);
   endtask

   task automatic fetch_op(input string tag, input logic [31:0] addr, input int waits,
                           input logic [31:0] rd);
      bit mis;
      int n;
      mis = (addr % 4) != 0;
      i_req = 1'b1; i_addr = addr;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req && !i_ready && n < 20);
      check({tag, " latency"}, 32'(n), 32'd1);
      if (mis) begin
         check({tag, " mis ready"}, {30'd0, i_ready, i_misalign}, 32'd3);
         check({tag, " mis rdata"}, i_rdata, 32'd0);
         check({tag, " mis no req"}, 32'(mem_req), 32'd0);
      end else begin
         check({tag, " addr"}, mem_addr, addr);
         check({tag, " be/wen"}, {27'd0, mem_be, mem_wen}, 32'h1E);
         for (int k = 0; k < waits; k++) @(negedge clk);
         check({tag, " held"}, 32'(mem_req), 32'd1);
         mem_ack = 1'b1; mem_rdata = rd;
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = $urandom;
         check({tag, " ready"}, {30'd0, i_ready, i_misalign}, 32'd2);
         check({tag, " rdata"}, i_rdata, rd);
      end
      i_req = 1'b0;
      @(negedge clk);
      check({tag, " ready pulse"}, 32'(i_ready), 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic [1:0]  w;
      int          n;
      rst = 1'b1; i_req = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
      d_addr = '0; d_wdata = '0; d_width = 2'd0; d_load_unsigned = 1'b0;
      mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("reset mem_req/wen/be", {27'd0, mem_req, mem_wen, mem_be}, 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset mem_wdata", mem_wdata, 32'd0);
      check("reset ready/mis", {28'd0, i_ready, d_ready, i_misalign, d_misalign}, 32'd0);
      check("reset i_rdata", i_rdata, 32'd0);
      check("reset d_rdata", d_rdata, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      fetch_op("fetch 0x100", 32'h100, 0, 32'h00A00093);
      data_op("lb 0x203", 1'b0, 1'b1, 32'h203, 32'h0, 2'd0, 1'b0, 0, 32'h80123456, got);
      check("lb 0x203 value", got, 32'hFFFFFF80);
      data_op("lbu 0x203", 1'b0, 1'b1, 32'h203, 32'h0, 2'd0, 1'b1, 0, 32'h80123456, got);
      check("lbu 0x203 value", got, 32'h00000080);
      data_op("sh 0x42", 1'b1, 1'b0, 32'h42, 32'hDEADBEEF, 2'd1, 1'b0, 3, 32'h0, got);
      check("sh 0x42 be", 32'(ref_be(2'd1, 32'h42)), 32'hC);
      data_op("lw 0x41", 1'b0, 1'b1, 32'h41, 32'h0, 2'd2, 1'b0, 0, 32'h0, got);
      check("lw 0x41 value", got, 32'd0);
      fetch_op("fetch 0x102", 32'h102, 0, 32'h0);

      // Simultaneous fetch and load: data must be served first.
      i_req = 1'b1; i_addr = 32'h300;
      d_ren = 1'b1; d_addr = 32'h400; d_width = 2'd2; d_load_unsigned = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_req && n < 20);
      check("arb first addr", mem_addr, 32'h400);
      mem_ack = 1'b1; mem_rdata = 32'h11112222;
      @(negedge clk);
      mem_ack = 1'b0;
      check("arb d first", {30'd0, d_ready, i_ready}, 32'd2);
      check("arb d rdata", d_rdata, 32'h11112222);
      d_ren = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_req && n < 20);
      check("arb second addr", mem_addr, 32'h300);
      mem_ack = 1'b1; mem_rdata = 32'h33334444;
      @(negedge clk);
      mem_ack = 1'b0;
      check("arb i second", {30'd0, d_ready, i_ready}, 32'd1);
      check("arb i rdata", i_rdata, 32'h33334444);
      i_req = 1'b0;
      @(negedge clk);

      // Reset during a store: request drops, late ack ignored, no completion.
      d_wen = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678; d_width = 2'd2;
      n = 0;
      do begin @(negedge clk); n++; end while (!mem_req && n < 20);
      check("rst busy req", 32'(mem_req), 32'd1);
      rst = 1'b1; mem_ack = 1'b1;
      @(negedge clk);
      check("rst drops req", {30'd0, mem_req, d_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b0; d_wen = 1'b0;
      @(negedge clk);
      check("rst state idle", 32'(dut.state), 32'(IDLE));
      check("rst no ready", {29'd0, mem_req, d_ready, d_misalign}, 32'd0);

      for (int it = 0; it < 60; it++) begin
         a = $urandom & 32'hFFFF;
         if ($urandom_range(0, 2) == 0) begin
            if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
            fetch_op("rnd fetch", a, $urandom_range(0, 3), $urandom);
         end else begin
            w = 2'($urandom_range(0, 3));
            n = $urandom_range(0, 2);
            data_op("rnd data", n != 0, n != 1, a, $urandom, w, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), $urandom, got);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one word-wide memory port between instruction fetch and the data-memory path driven by the decoder's dmem command (wen/ren/load_unsigned/width).
- Arbitrates the two requesters and sequences each access through a small FSM.
- Formats stores into byte lanes and byte enables, and extracts and sign- or zero-extends loads.
- Sits between the core (fetch and execute/mem logic) and the memory model or bus.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 4 byte lanes.
- DATA_FIRST, 1, 1 = data request wins over fetch when both are pending in IDLE; 0 = fetch wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction fetch request; held until i_ready.
- i_addr  in  ADDR_W  fetch byte address.
- i_rdata  out  32  fetched word; valid while i_ready.
- i_ready  out  1  one-cycle completion pulse for fetch.
- i_misalign  out  1  qualifies i_ready: i_addr[1:0] != 0, no memory access made.
- d_ren  in  1  load request; held until d_ready.
- d_wen  in  1  store request; held until d_ready; wins over d_ren if both are set.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_width  in  LDST_WIDTH_W  00 byte, 01 half, 10 word; 11 treated as misaligned.
- d_load_unsigned  in  1  1 = zero-extend, 0 = sign-extend byte/half loads.
- d_rdata  out  32  formatted load data; valid while d_ready.
- d_ready  out  1  one-cycle completion pulse for data.
- d_misalign  out  1  qualifies d_ready: access misaligned, no memory access made.
- mem_req  out  1  memory request, held until mem_ack.
- mem_wen  out  1  write strobe.
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_rdata  in  32  read data; valid when mem_ack.
- mem_ack  in  1  access complete; sampled only while mem_req = 1.

Behaviour:
- Reset: state IDLE. All outputs 0: mem_req, mem_wen, mem_addr, mem_wdata, mem_be, i_ready, d_ready, i_rdata, d_rdata, i_misalign, d_misalign.
- A reset asserted mid-access drops mem_req on the next cycle; any in-flight mem_ack is ignored.

FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE, request pending: winner chosen per DATA_FIRST.
  - Misaligned winner goes directly to RESP_x with the misalign flag set and rdata = 0.
  - Otherwise registers mem_addr, mem_wen, mem_wdata and mem_be, and goes to BUSY_x.
- BUSY_x: mem_req = 1 with all mem_* outputs stable.
  - On mem_ack: capture formatted mem_rdata into i_rdata/d_rdata, deassert mem_req, go to RESP_x.
  - mem_wen = 1 writes capture rdata = 0.
- RESP_x: x_ready = 1 for exactly one cycle, then IDLE.
  - The requester must deassert or change its request in the cycle after ready, so IDLE re-samples fresh requests.
- Latency: request seen in IDLE at cycle 0 → mem_req at cycle 1 → ready at cycle 2 (mem_ack at cycle 1). Each extra wait cycle adds 1.
- Misaligned accesses return in 1 cycle (ready at cycle 1).
- Back-to-back: at most one access in flight; no new grant is made in BUSY or RESP states.
- Requests arriving during BUSY or RESP wait, not lost.
- Store lanes, lane = d_addr[1:0]:
  - Byte: be = 4'b0001 << lane; wdata = {4{d_wdata[7:0]}}.
  - Half: requires lane[0] = 0; be = 4'b0011 << lane; wdata = {2{d_wdata[15:0]}}.
  - Word: requires lane = 0; be = 4'b1111; wdata = d_wdata.
- Loads: mem_be = 4'b1111.
  - Byte: extract mem_rdata[8*lane +: 8] and extend per d_load_unsigned.
  - Half: extract mem_rdata[16*lane[1] +: 16] and extend per d_load_unsigned.
  - Word: pass mem_rdata through.
- Fetch: be = 4'b1111, mem_wen = 0, data passed unchanged.
- Outputs ready and misalign are low in every state except RESP.

Decomposition:
- rv32ima_pkg additions:
  - LDST_WIDTH_W = 2.
  - ldst_width_t enum {LDST_B = 0, LDST_H = 1, LDST_W = 2}.
  - memarb_state_t enum of the 5 states.
- Sub-module mem_lane_fmt, purely combinational, shared by load and store paths:
  - Inputs: width, lane, load_unsigned, wdata, rdata.
  - Outputs: be, wdata_rep, rdata_ext, misalign.

Test Plan:
- Reset held 2 cycles during BUSY_D → mem_req = 0 the cycle after; no d_ready; FSM in IDLE.
- Fetch i_addr = 0x100, mem_ack 1 cycle after mem_req, mem_rdata = 0x00A00093 → mem_addr = 0x100, be = 1111; i_ready at cycle 2 with i_rdata = 0x00A00093.
- Signed byte load d_addr = 0x203, mem_rdata = 0x80123456 → mem_addr = 0x200; d_rdata = 0xFFFFFF80. Repeat with d_load_unsigned = 1 → 0x00000080.
- Half store d_addr = 0x42, d_wdata = 0xDEADBEEF → mem_addr = 0x40, mem_be = 1100, mem_wen = 1, mem_wdata = 0xBEEFBEEF; d_ready after 3 wait cycles of mem_ack low.
- Word load d_addr = 0x41 → no mem_req; d_ready and d_misalign = 1 at cycle 1, d_rdata = 0.
- i_req and d_ren asserted together, DATA_FIRST = 1 → data access first, d_ready; then fetch granted; i_ready follows. Both complete, order D then I.
